// File: rtl/ysyx_041514_ifu_resp.sv
// rtl/ysyx_041514_ifu_resp.sv - instruction-fetch responder: line-buffer hit or 64-bit AR/R miss fill
// Optional 64-bit tagged line buffer enabled by defining YSYX_041514_IFU_LINEBUF_EN.
module ysyx_041514_ifu_resp #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int          LINE_W   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_req_i,
    input  logic [31:0]       pc_next_i,
    input  logic              flush_i,
    input  logic              fence_i_i,
    output logic              inst_valid_o,
    output logic [31:0]       inst_o,
    output logic [63:0]       inst_pc_o,
    output logic              inst_fault_o,
    output logic              if_stall_req_o,
    output logic              mem_ar_valid_o,
    input  logic              mem_ar_ready_i,
    output logic [31:0]       mem_ar_addr_o,
    input  logic              mem_r_valid_i,
    output logic              mem_r_ready_o,
    input  logic [LINE_W-1:0] mem_r_data_i,
    input  logic [1:0]        mem_r_resp_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_miss_addr;
    logic               r_kill;

    logic               w_hit;
    logic [LINE_W-1:0]  w_buf_data;
    logic               w_start_miss;
    logic               w_r_done;
    logic               w_fill;
    logic               w_inval;
    logic               w_resp_valid;
    logic               w_resp_fault;
    logic [31:0]        w_resp_inst;
    logic [31:0]        w_resp_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_start_miss = 1'b0;
        w_r_done     = 1'b0;
        w_fill       = 1'b0;
        w_inval      = 1'b0;
        w_resp_valid = 1'b0;
        w_resp_fault = 1'b0;
        w_resp_inst  = 32'h0;
        w_resp_pc    = r_miss_addr;
        case (r_state)
            S_IDLE: begin
                if (read_req_i && !flush_i) begin
                    w_resp_pc = pc_next_i;
                    if (pc_next_i[1:0] != 2'b00) begin
                        w_resp_valid = 1'b1;
                        w_resp_fault = 1'b1;
                    end else if (w_hit) begin
                        w_resp_valid = 1'b1;
                        w_resp_inst  = pc_next_i[2] ? w_buf_data[LINE_W-1:LINE_W/2]
                                                    : w_buf_data[LINE_W/2-1:0];
                    end else begin
                        w_start_miss = 1'b1;
                        w_state_nxt  = S_AR;
                    end
                end
            end
            S_AR: begin
                if (mem_ar_ready_i) begin
                    w_state_nxt = S_R;
                end
            end
            S_R: begin
                if (mem_r_valid_i) begin
                    w_r_done    = 1'b1;
                    w_state_nxt = S_IDLE;
                    if (mem_r_resp_i == 2'b00) begin
                        w_fill      = 1'b1;
                        w_resp_inst = r_miss_addr[2] ? mem_r_data_i[LINE_W-1:LINE_W/2]
                                                     : mem_r_data_i[LINE_W/2-1:0];
                    end else begin
                        w_inval      = 1'b1;
                        w_resp_fault = 1'b1;
                    end
                    // A flush arriving on the completion edge counts as a kill.
                    w_resp_valid = !(r_kill || flush_i);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_miss_addr  <= 32'h0;
            r_kill       <= 1'b0;
            inst_valid_o <= 1'b0;
            inst_fault_o <= 1'b0;
            inst_o       <= 32'h0;
            inst_pc_o    <= RESET_PC;
        end else begin
            if (w_start_miss) begin
                r_miss_addr <= pc_next_i;
            end
            r_kill       <= (r_state != S_IDLE) && !w_r_done && (r_kill || flush_i);
            inst_valid_o <= w_resp_valid;
            inst_fault_o <= w_resp_valid && w_resp_fault;
            if (w_resp_valid) begin
                inst_o    <= w_resp_inst;
                inst_pc_o <= {32'h0, w_resp_pc};
            end
        end
    end

    assign if_stall_req_o = (r_state != S_IDLE);
    assign mem_ar_valid_o = (r_state == S_AR);
    assign mem_r_ready_o  = (r_state == S_R);
    assign mem_ar_addr_o  = {r_miss_addr[31:3], 3'b000};

`ifdef YSYX_041514_IFU_LINEBUF_EN
    logic              r_buf_valid;
    logic [28:0]       r_buf_tag;
    logic [LINE_W-1:0] r_buf_data;

    // Fence has priority over a coincident fill so the line ends invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_valid <= 1'b0;
            r_buf_tag   <= 29'h0;
            r_buf_data  <= '0;
        end else begin
            if (w_fill) begin
                r_buf_tag  <= r_miss_addr[31:3];
                r_buf_data <= mem_r_data_i;
            end
            if (fence_i_i) begin
                r_buf_valid <= 1'b0;
            end else if (w_fill) begin
                r_buf_valid <= 1'b1;
            end else if (w_inval) begin
                r_buf_valid <= 1'b0;
            end
        end
    end

    assign w_hit      = r_buf_valid && (r_buf_tag == pc_next_i[31:3]);
    assign w_buf_data = r_buf_data;
`else
    logic w_unused;

    assign w_hit      = 1'b0;
    assign w_buf_data = '0;
    assign w_unused   = ^{fence_i_i, w_fill, w_inval};
`endif

endmodule

// File: tb/tb_ysyx_041514_ifu_resp.sv
// tb/tb_ysyx_041514_ifu_resp.sv - scoreboard bench for ysyx_041514_ifu_resp with randomized fetches
module tb_ysyx_041514_ifu_resp;
`ifdef YSYX_041514_IFU_LINEBUF_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        read_req_i = 1'b0;
    logic [31:0] pc_next_i = 32'h0;
    logic        flush_i = 1'b0;
    logic        fence_i_i = 1'b0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [63:0] inst_pc_o;
    logic        inst_fault_o;
    logic        if_stall_req_o;
    logic        mem_ar_valid_o;
    logic        mem_ar_ready_i;
    logic [31:0] mem_ar_addr_o;
    logic        mem_r_valid_i;
    logic        mem_r_ready_o;
    logic [63:0] mem_r_data_i;
    logic [1:0]  mem_r_resp_i;

    ysyx_041514_ifu_resp dut (
        .clk            (clk),
        .rst            (rst),
        .read_req_i     (read_req_i),
        .pc_next_i      (pc_next_i),
        .flush_i        (flush_i),
        .fence_i_i      (fence_i_i),
        .inst_valid_o   (inst_valid_o),
        .inst_o         (inst_o),
        .inst_pc_o      (inst_pc_o),
        .inst_fault_o   (inst_fault_o),
        .if_stall_req_o (if_stall_req_o),
        .mem_ar_valid_o (mem_ar_valid_o),
        .mem_ar_ready_i (mem_ar_ready_i),
        .mem_ar_addr_o  (mem_ar_addr_o),
        .mem_r_valid_i  (mem_r_valid_i),
        .mem_r_ready_o  (mem_r_ready_o),
        .mem_r_data_i   (mem_r_data_i),
        .mem_r_resp_i   (mem_r_resp_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        fault;
        logic [31:0] inst;
        logic [63:0] pc;
    } resp_t;

    resp_t       exp_q[$];
    resp_t       mon_e;
    int          checks = 0;
    int          failures = 0;

    bit          m_valid = 1'b0;
    logic [28:0] m_line = 29'h0;

    int          ar_delay = 0;
    int          r_delay = 0;
    logic [1:0]  r_resp = 2'b00;
    logic [31:0] exp_ar_addr = 32'h0;
    int          ar_count = 0;
    int          rs = 0;
    int          rcnt = 0;

    int          k;
    int          n;
    int          md;
    logic [31:0] a_r;
    logic [1:0]  rsp_r;

    function automatic logic [63:0] mem_line(input logic [28:0] l);
        logic [31:0] x;
        if (l == 29'h1000_0000) return 64'h00100093_00000413;
        x = {3'b000, l};
        return {x ^ 32'hA5A5_0F0F, x * 32'h9E37_79B9 + 32'h1234_5678};
    endfunction

    function automatic logic [31:0] half(input logic [63:0] d, input logic hi);
        return hi ? d[63:32] : d[31:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every valid response must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && inst_valid_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_resp actual=%h/%h/%h expected=none",
                             inst_fault_o, inst_o, inst_pc_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({inst_fault_o, inst_o, inst_pc_o} !== mon_e) begin
                        failures++;
                        $display("FAIL resp actual=%h/%h/%h expected=%h/%h/%h",
                                 inst_fault_o, inst_o, inst_pc_o, mon_e.fault, mon_e.inst, mon_e.pc);
                    end
                end
                chk("stall_with_valid", {63'h0, if_stall_req_o}, 64'h0);
            end
        end
    end

    // Memory slave with programmable AR/R latency and response code.
    initial begin
        mem_ar_ready_i = 1'b0;
        mem_r_valid_i  = 1'b0;
        mem_r_data_i   = 64'h0;
        mem_r_resp_i   = 2'b00;
        forever begin
            @(negedge clk);
            mem_ar_ready_i = 1'b0;
            mem_r_valid_i  = 1'b0;
            if (rst) begin
                rs   = 0;
                rcnt = 0;
            end else if (rs == 0) begin
                if (mem_ar_valid_o) begin
                    chk("ar_addr", {32'h0, mem_ar_addr_o}, {32'h0, exp_ar_addr});
                    chk("ar_stall_novalid", {62'h0, if_stall_req_o, inst_valid_o}, 64'h2);
                    if (rcnt < ar_delay) begin
                        rcnt++;
                    end else begin
                        mem_ar_ready_i = 1'b1;
                        rs = 1;
                        rcnt = 0;
                        ar_count++;
                    end
                end
            end else if (mem_r_ready_o) begin
                if (rcnt < r_delay) begin
                    rcnt++;
                end else begin
                    mem_r_valid_i = 1'b1;
                    mem_r_data_i  = mem_line(exp_ar_addr[31:3]);
                    mem_r_resp_i  = r_resp;
                    rs = 0;
                    rcnt = 0;
                end
            end
        end
    end

    // mode: 0 plain, 1 flush together with the request, 2 flush at a random stall cycle
    task automatic do_req(input logic [31:0] a, input int mode, input int ar_d, input int r_d,
                          input logic [1:0] resp);
        bit   exp_miss;
        bit   killed;
        int   ar0;
        int   cyc;
        int   fl_at;
        resp_t e;
        ar_delay = ar_d;
        r_delay  = r_d;
        r_resp   = resp;
        ar0      = ar_count;
        exp_miss = 1'b0;
        killed   = 1'b0;
        fl_at    = $urandom_range(0, ar_d + r_d);
        @(negedge clk);
        read_req_i = 1'b1;
        pc_next_i  = a;
        flush_i    = (mode == 1);
        if (mode == 1) begin
            exp_miss = 1'b0;
        end else if (a[1:0] != 2'b00) begin
            e = '{fault: 1'b1, inst: 32'h0, pc: {32'h0, a}};
            exp_q.push_back(e);
        end else if (BUF && m_valid && m_line == a[31:3]) begin
            e = '{fault: 1'b0, inst: half(mem_line(a[31:3]), a[2]), pc: {32'h0, a}};
            exp_q.push_back(e);
        end else begin
            exp_miss    = 1'b1;
            killed      = (mode == 2);
            exp_ar_addr = {a[31:3], 3'b000};
            if (!killed) begin
                e = '{fault: (resp != 2'b00), inst: (resp == 2'b00) ? half(mem_line(a[31:3]), a[2]) : 32'h0,
                      pc: {32'h0, a}};
                exp_q.push_back(e);
            end
            if (BUF) begin
                m_valid = (resp == 2'b00);
                m_line  = a[31:3];
            end
        end
        @(negedge clk);
        read_req_i = 1'b0;
        flush_i    = 1'b0;
        cyc = 0;
        while (if_stall_req_o && cyc < 300) begin
            flush_i = killed && (cyc == fl_at);
            @(negedge clk);
            cyc++;
        end
        flush_i = 1'b0;
        chk("stall_release", {63'h0, if_stall_req_o}, 64'h0);
        chk("ar_count", 64'(ar_count - ar0), exp_miss ? 64'h1 : 64'h0);
        @(negedge clk);
    endtask

    task automatic do_fence();
        @(negedge clk);
        fence_i_i = 1'b1;
        @(negedge clk);
        fence_i_i = 1'b0;
        if (BUF) m_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", {63'h0, inst_valid_o}, 64'h0);
        chk("rst_fault", {63'h0, inst_fault_o}, 64'h0);
        chk("rst_inst", {32'h0, inst_o}, 64'h0);
        chk("rst_pc", inst_pc_o, 64'h8000_0000);
        chk("rst_stall", {63'h0, if_stall_req_o}, 64'h0);
        chk("rst_bus", {62'h0, mem_ar_valid_o, mem_r_ready_o}, 64'h0);
        rst = 1'b0;

        do_req(32'h8000_0000, 0, 0, 2, 2'b00);
        do_req(32'h8000_0004, 0, 0, 0, 2'b00);
        do_req(32'h8000_0008, 0, 3, 1, 2'b00);
        do_req(32'h8000_0010, 0, 0, 1, 2'b10);
        do_req(32'h8000_0014, 0, 0, 1, 2'b00);
        do_req(32'h8000_0020, 2, 1, 3, 2'b00);
        do_req(32'h8000_0024, 0, 0, 0, 2'b00);
        do_req(32'h8000_0002, 0, 0, 0, 2'b00);
        do_fence();
        do_req(32'h8000_0020, 0, 0, 0, 2'b00);
        do_req(32'h8000_0028, 1, 0, 0, 2'b00);

        ar_delay = 0;
        r_delay  = 30;
        r_resp   = 2'b00;
        exp_ar_addr = 32'h8000_0040;
        @(negedge clk);
        read_req_i = 1'b1;
        pc_next_i  = 32'h8000_0040;
        @(negedge clk);
        read_req_i = 1'b0;
        n = 0;
        while (!mem_r_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("reached_r", {63'h0, mem_r_ready_o}, 64'h1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("amid_stall", {63'h0, if_stall_req_o}, 64'h0);
        chk("amid_valid", {63'h0, inst_valid_o}, 64'h0);
        chk("amid_pc", inst_pc_o, 64'h8000_0000);
        chk("amid_bus", {62'h0, mem_ar_valid_o, mem_r_ready_o}, 64'h0);
        m_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 160; i++) begin
            k = $urandom_range(0, 15);
            if (k == 0) begin
                do_fence();
            end else begin
                a_r = 32'h8000_0000 + ($urandom_range(0, 5) << 3) + ($urandom_range(0, 1) << 2);
                if (k == 1) a_r = a_r + $urandom_range(1, 3);
                md = (k == 2) ? 1 : ((k == 3 || k == 4) ? 2 : 0);
                rsp_r = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                do_req(a_r, md, $urandom_range(0, 3), $urandom_range(0, 3), rsp_r);
            end
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
